// File: rtl/shifter_pkg.sv
// Shared mode encodings and width helper for the pipelined barrel shifter.
package shifter_pkg;

    typedef enum logic [2:0] {
        MODE_SRL = 3'b000,
        MODE_SLL = 3'b001,
        MODE_SRA = 3'b010,
        MODE_ROR = 3'b011,
        MODE_ROL = 3'b100
    } shift_mode_e;

    localparam logic [2:0] MODE_LAST_LEGAL = 3'b100;

    // ceil(log2(w)); w is expected to be a power of two.
    function automatic int shw_of(input int w);
        int r;
        r = 0;
        for (int i = 0; i < 8; i++) begin
            if ((1 << i) < w) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/shifter_stage.sv
// One pipeline stage: conditional shift/rotate by DIST followed by an enabled register.
module shifter_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIST  = 1,
    localparam int SHW  = shw_of(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic [SHW-1:0]   amt_i,
    input  logic [2:0]       mode_i,
    input  logic             err_i,
    input  logic             sign_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic [SHW-1:0]   amt_o,
    output logic [2:0]       mode_o,
    output logic             err_o,
    output logic             sign_o
);

    localparam int BIT = shw_of(DIST);

    logic             valid_d, valid_q;
    logic [WIDTH-1:0] data_d, data_q;
    logic [SHW-1:0]   amt_d, amt_q;
    logic [2:0]       mode_d, mode_q;
    logic             err_d, err_q;
    logic             sign_d, sign_q;
    logic [WIDTH-1:0] shifted;

    always_comb begin
        shifted = data_i;
        case (mode_i)
            MODE_SRL: shifted = data_i >> DIST;
            MODE_SLL: shifted = data_i << DIST;
            // sign_i is the operand's original MSB, so earlier stages cannot corrupt the fill
            MODE_SRA: shifted = (data_i >> DIST) | ({WIDTH{sign_i}} << (WIDTH - DIST));
            MODE_ROR: shifted = (data_i >> DIST) | (data_i << (WIDTH - DIST));
            MODE_ROL: shifted = (data_i << DIST) | (data_i >> (WIDTH - DIST));
            default:  shifted = data_i;
        endcase

        valid_d = valid_i;
        data_d  = (amt_i[BIT] && !err_i) ? shifted : data_i;
        amt_d   = amt_i;
        mode_d  = mode_i;
        err_d   = err_i;
        sign_d  = sign_i;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            amt_q   <= '0;
            mode_q  <= '0;
            err_q   <= 1'b0;
            sign_q  <= 1'b0;
        end else if (en) begin
            valid_q <= valid_d;
            data_q  <= data_d;
            amt_q   <= amt_d;
            mode_q  <= mode_d;
            err_q   <= err_d;
            sign_q  <= sign_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign amt_o   = amt_q;
    assign mode_o  = mode_q;
    assign err_o   = err_q;
    assign sign_o  = sign_q;

endmodule

// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter/rotator: SHW stages, each stage handles one bit of the amount.
module shifter_pipe
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    localparam int SHW  = shw_of(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dataA,
    input  logic [SHW-1:0]   dataB,
    input  logic [2:0]       Signal,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dataOut,
    output logic             out_err,
    output logic             busy
);

    logic [SHW:0]     valid_s;
    logic [SHW:0]     err_s;
    logic [SHW:0]     sign_s;
    logic [WIDTH-1:0] data_s [SHW+1];
    logic [SHW-1:0]   amt_s  [SHW+1];
    logic [2:0]       mode_s [SHW+1];
    logic             advance;

    // The whole pipe moves as one; a stalled output freezes every stage.
    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance;

    assign valid_s[0] = in_valid;
    assign data_s[0]  = dataA;
    assign amt_s[0]   = dataB;
    assign mode_s[0]  = Signal;
    assign err_s[0]   = (Signal > MODE_LAST_LEGAL);
    assign sign_s[0]  = dataA[WIDTH-1];

    for (genvar i = 0; i < SHW; i++) begin : g_stage
        shifter_stage #(
            .WIDTH (WIDTH),
            .DIST  (1 << i)
        ) u_stage (
            .clk     (clk),
            .reset   (reset),
            .en      (advance),
            .valid_i (valid_s[i]),
            .data_i  (data_s[i]),
            .amt_i   (amt_s[i]),
            .mode_i  (mode_s[i]),
            .err_i   (err_s[i]),
            .sign_i  (sign_s[i]),
            .valid_o (valid_s[i+1]),
            .data_o  (data_s[i+1]),
            .amt_o   (amt_s[i+1]),
            .mode_o  (mode_s[i+1]),
            .err_o   (err_s[i+1]),
            .sign_o  (sign_s[i+1])
        );
    end

    assign out_valid = valid_s[SHW];
    assign dataOut   = data_s[SHW];
    assign out_err   = err_s[SHW];
    assign busy      = |valid_s[SHW:1];

endmodule
